// File: rtl/dmem_access_ctrl_if.sv
// Request/response bundle between one requester (load/store unit or debug port)
// and the data-memory access controller.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, we, funct3, addr, wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, we, funct3, addr, wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin sequencer in front of a word-only registered-read data memory;
// performs RV32I sub-word loads and sb/sh via read-modify-write.
module dmem_access_ctrl #(
  parameter int DMEM_BYTES = 128,
  parameter int ADDR_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  dmem_access_ctrl_if.slave p0,
  dmem_access_ctrl_if.slave p1,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_RESP} state_e;

  state_e            state_q;
  logic              last_grant_q;
  logic              gnt_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [1:0]        rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rdata_q;

  logic              gnt_d;
  logic              accept;
  logic              sel_we;
  logic [2:0]        sel_f3;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_err;

  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [ADDR_W-1:0] addr);
    logic legal;
    logic misaligned;
    logic out_of_range;
    case (f3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~we;
      default:                legal = 1'b0;
    endcase
    misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                   ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = (addr >= ADDR_W'(DMEM_BYTES));
    return ~legal | misaligned | out_of_range;
  endfunction

  function automatic logic [31:0] word_addr(input logic [ADDR_W-1:0] addr);
    return 32'({addr[ADDR_W-1:2], 2'b00});
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word, input logic [31:0] wd);
    logic [31:0] m;
    m = word;
    if (f3[1:0] == 2'b00)      m[{off, 3'b000} +: 8]     = wd[7:0];
    else if (f3[1:0] == 2'b01) m[{off[1], 4'b0000} +: 16] = wd[15:0];
    else                       m = wd;
    return m;
  endfunction

  // Both valid -> the port that did not win last; a lone valid port always wins.
  always_comb begin
    gnt_d     = p1.req_valid & (~p0.req_valid | ~last_grant_q);
    accept    = (state_q == S_IDLE) & (p0.req_valid | p1.req_valid);
    sel_we    = gnt_d ? p1.we     : p0.we;
    sel_f3    = gnt_d ? p1.funct3 : p0.funct3;
    sel_addr  = gnt_d ? p1.addr   : p0.addr;
    sel_wdata = gnt_d ? p1.wdata  : p0.wdata;
    sel_err   = req_error(sel_we, sel_f3, sel_addr);
  end

  assign p0.req_ready = accept & ~gnt_d;
  assign p1.req_ready = accept &  gnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp_valid_q  <= '0;
    end else begin
      mem_we_q    <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: if (accept) begin
          gnt_q        <= gnt_d;
          last_grant_q <= gnt_d;
          we_q         <= sel_we;
          f3_q         <= sel_f3;
          addr_q       <= sel_addr;
          wdata_q      <= sel_wdata;
          if (sel_err) begin
            rsp_valid_q <= {gnt_d, ~gnt_d};
            rsp_err_q   <= 1'b1;
            rdata_q     <= '0;
            state_q     <= S_RESP;
          end else if (sel_we && sel_f3[1:0] == 2'b10) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= word_addr(sel_addr);
            mem_wdata_q <= sel_wdata;
            state_q     <= S_WRITE;
          end else begin
            mem_addr_q <= word_addr(sel_addr);
            state_q    <= S_READ;
          end
        end
        S_READ: state_q <= S_CAPTURE;
        S_CAPTURE: begin
          if (we_q) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= store_merge(f3_q, addr_q[1:0], mem_rdata_i, wdata_q);
            state_q     <= S_WRITE;
          end else begin
            rdata_q     <= load_extract(f3_q, addr_q[1:0], mem_rdata_i);
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= {gnt_q, ~gnt_q};
            state_q     <= S_RESP;
          end
        end
        S_WRITE: begin
          rdata_q     <= '0;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= {gnt_q, ~gnt_q};
          state_q     <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Response payload is gated so the idle port always presents zeros.
  assign p0.rsp_valid = rsp_valid_q[0];
  assign p0.rsp_rdata = rsp_valid_q[0] ? rdata_q : 32'd0;
  assign p0.rsp_err   = rsp_valid_q[0] & rsp_err_q;
  assign p1.rsp_valid = rsp_valid_q[1];
  assign p1.rsp_rdata = rsp_valid_q[1] ? rdata_q : 32'd0;
  assign p1.rsp_err   = rsp_valid_q[1] & rsp_err_q;

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: table of single transactions plus hand-written
// arbitration and reset-abort sequences, against a 32-word registered-read memory.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem [32];

  int n_checks = 0;
  int n_pass   = 0;

  dmem_access_ctrl_if #(.ADDR_W(32)) p0_if ();
  dmem_access_ctrl_if #(.ADDR_W(32)) p1_if ();

  dmem_access_ctrl #(.DMEM_BYTES(128), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .p0          (p0_if),
    .p1          (p1_if),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[6:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[6:2]];
  end

  typedef struct {
    int          port;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_nwe;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic drive(input int port, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (port == 0) begin
      p0_if.req_valid = v; p0_if.we = we; p0_if.funct3 = f3; p0_if.addr = a; p0_if.wdata = wd;
    end else begin
      p1_if.req_valid = v; p1_if.we = we; p1_if.funct3 = f3; p1_if.addr = a; p1_if.wdata = wd;
    end
  endtask

  function automatic logic rdy(input int port);
    return (port == 0) ? p0_if.req_ready : p1_if.req_ready;
  endfunction
  function automatic logic rv(input int port);
    return (port == 0) ? p0_if.rsp_valid : p1_if.rsp_valid;
  endfunction
  function automatic logic [31:0] rd(input int port);
    return (port == 0) ? p0_if.rsp_rdata : p1_if.rsp_rdata;
  endfunction
  function automatic logic re(input int port);
    return (port == 0) ? p0_if.rsp_err : p1_if.rsp_err;
  endfunction

  function automatic vec_t mk(input int port, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] erd,
                              input logic eerr, input int lat, input int nwe,
                              input logic [31:0] ma, input logic [31:0] mwd);
    vec_t v;
    v.port = port; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = erd;
    v.exp_err = eerr; v.exp_lat = lat; v.exp_nwe = nwe; v.exp_maddr = ma; v.exp_mwdata = mwd;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0;
    int lat = 1;
    int nwe = 0;
    int noisy = 0;
    logic got = 1'b0;
    logic [31:0] grd = '0;
    logic gerr = 1'b0;
    logic [31:0] la = '0;
    logic [31:0] lwd = '0;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.f3, v.addr, v.wdata);
    #1;
    while (!rdy(v.port) && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    chk({tag, "_ready"}, 32'(rdy(v.port)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(v.port, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    while (!got && lat <= 12) begin
      if (mem_we) begin nwe++; la = mem_addr; lwd = mem_wdata; end
      if (rv(1 - v.port) || rd(1 - v.port) != 0 || re(1 - v.port)) noisy++;
      if (rv(v.port)) begin
        got = 1'b1; grd = rd(v.port); gerr = re(v.port);
      end else begin
        @(negedge clk); lat++;
      end
    end
    chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_rdata"}, grd, v.exp_rdata);
    chk({tag, "_err"}, 32'(gerr), 32'(v.exp_err));
    chk({tag, "_mem_we_pulses"}, 32'(nwe), 32'(v.exp_nwe));
    chk({tag, "_other_port_quiet"}, 32'(noisy), 32'd0);
    if (v.exp_nwe != 0) begin
      chk({tag, "_mem_addr"}, la, v.exp_maddr);
      chk({tag, "_mem_wdata"}, lwd, v.exp_mwdata);
    end
    @(negedge clk);
    chk({tag, "_rsp_one_cycle"}, 32'(rv(v.port)), 32'd0);
  endtask

  initial begin
    int grants[4];
    int ng = 0;
    int last_g = -1;
    int misroute = 0;
    int both_rdy = 0;
    int nrsp = 0;
    int bad = 0;

    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_rsp_valid", {30'd0, p1_if.rsp_valid, p0_if.rsp_valid}, 32'd0);
    chk("reset_rsp_payload", p0_if.rsp_rdata | p1_if.rsp_rdata, 32'd0);
    chk("reset_ready_idle", {30'd0, p1_if.req_ready, p0_if.req_ready}, 32'd0);

    // Both ports stream word stores; grants must alternate starting with port 0.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 3'b010, 32'h00, 32'hA0A0A0A0);
    drive(1, 1'b1, 1'b1, 3'b010, 32'h10, 32'h55667788);
    for (int c = 0; c < 15; c++) begin
      #1;
      if (c == 12) begin
        drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        #1;
      end
      if (p0_if.req_ready && p1_if.req_ready) both_rdy++;
      if (p0_if.rsp_valid) begin nrsp++; if (last_g != 0) misroute++; end
      if (p1_if.rsp_valid) begin nrsp++; if (last_g != 1) misroute++; end
      if (p0_if.rsp_valid && p1_if.rsp_valid) misroute++;
      if (p0_if.req_ready || p1_if.req_ready) begin
        last_g = p1_if.req_ready ? 1 : 0;
        if (ng < 4) grants[ng] = last_g;
        ng++;
      end
      @(negedge clk);
    end
    chk("arb_grant_count", 32'(ng), 32'd4);
    for (int g = 0; g < 4; g++) chk($sformatf("arb_grant%0d", g), 32'(grants[g]), 32'(g % 2));
    chk("arb_both_ready", 32'(both_rdy), 32'd0);
    chk("arb_rsp_count", 32'(nrsp), 32'd4);
    chk("arb_rsp_routing", 32'(misroute), 32'd0);

    vecs.push_back(mk(1, 1, 3'b010, 32'h04, 32'h8899AABB, 0, 0, 2, 1, 32'h04, 32'h8899AABB));
    vecs.push_back(mk(0, 0, 3'b000, 32'h05, 0, 32'hFFFFFFAA, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b100, 32'h05, 0, 32'h000000AA, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b001, 32'h06, 0, 32'hFFFF8899, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b101, 32'h06, 0, 32'h00008899, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b000, 32'h07, 0, 32'hFFFFFF88, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b100, 32'h04, 0, 32'h000000BB, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h06, 32'h00001234, 0, 0, 4, 1, 32'h04, 32'h1234AABB));
    vecs.push_back(mk(0, 0, 3'b010, 32'h04, 0, 32'h1234AABB, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h04, 32'hFFFFFF5A, 0, 0, 4, 1, 32'h04, 32'h1234AA5A));
    vecs.push_back(mk(0, 0, 3'b010, 32'h04, 0, 32'h1234AA5A, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b001, 32'h04, 0, 32'hFFFFAA5A, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h02, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b001, 32'h03, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h80, 32'h11111111, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b011, 32'h04, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3'b100, 32'h04, 32'h22, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b101, 32'h01, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h7F, 32'h3333, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b000, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h7C, 32'hDEADBEEF, 0, 0, 2, 1, 32'h7C, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 3'b010, 32'h7C, 0, 32'hDEADBEEF, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h7F, 32'h00000011, 0, 0, 4, 1, 32'h7C, 32'h11ADBEEF));
    vecs.push_back(mk(1, 0, 3'b100, 32'h7F, 0, 32'h00000011, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b101, 32'h7E, 0, 32'h000011AD, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h00, 0, 32'hA0A0A0A0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h10, 0, 32'h55667788, 0, 3, 0, 0, 0));
    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset during the CAPTURE cycle of an sb must abandon the read-modify-write.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 3'b000, 32'h11, 32'h000000EE);
    #1;
    chk("rstmid_ready", 32'(p0_if.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    if (mem_we || p0_if.rsp_valid || p1_if.rsp_valid) bad++;
    @(negedge clk);
    if (mem_we || p0_if.rsp_valid || p1_if.rsp_valid) bad++;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      reset = 1'b0;
      if (mem_we || p0_if.rsp_valid || p1_if.rsp_valid) bad++;
    end
    chk("rstmid_no_write_no_rsp", 32'(bad), 32'd0);
    run_vec(100, mk(0, 0, 3'b010, 32'h10, 0, 32'h55667788, 0, 3, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
